// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller: one req/ack SRAM transaction per access, with store alignment and load extension.
// Optional build macro MEM_ALIGN_CHECK_EN enables misalignment detection (adelM/adesM/badvaddrM).
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic [2:0]  lsopM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic        flushM,
    output logic        data_req,
    output logic        data_wr,
    output logic [31:0] data_addr,
    output logic [3:0]  data_be,
    output logic [31:0] data_wdata,
    input  logic [31:0] data_rdata,
    input  logic        data_ack,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        adelM,
    output logic        adesM,
    output logic [31:0] badvaddrM
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [1:0]  off_r;
    logic [2:0]  lsop_r;

    logic        wr_s;
    logic        active_s;
    logic        misaligned_s;
    logic        issue_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;

    // Select the addressed byte/halfword of the read word and extend it.
    function automatic logic [31:0] extract_load(input logic [2:0] op,
                                                 input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [15:0] half_v;
        logic [7:0]  byte_v;
        logic [31:0] res_v;
        half_v = off[1] ? rdata[31:16] : rdata[15:0];
        byte_v = rdata[{off, 3'b000} +: 8];
        case (op)
            3'b000:  res_v = rdata;
            3'b001:  res_v = {{16{half_v[15]}}, half_v};
            3'b010:  res_v = {16'h0000, half_v};
            3'b011:  res_v = {{24{byte_v[7]}}, byte_v};
            3'b100:  res_v = {24'h000000, byte_v};
            default: res_v = rdata;
        endcase
        return res_v;
    endfunction

    assign wr_s     = lsopM[2] & (lsopM != 3'b100);
    assign active_s = (state_r == IDLE) & memenM & ~flushM;
    assign issue_s  = active_s & ~misaligned_s;
    assign stallM   = issue_s | (state_r == WAIT);

`ifdef MEM_ALIGN_CHECK_EN
    logic is_half_s;
    logic is_word_s;
    assign is_half_s    = (lsopM == 3'b001) | (lsopM == 3'b010) | (lsopM == 3'b110);
    assign is_word_s    = (lsopM == 3'b000) | (lsopM == 3'b101);
    assign misaligned_s = (is_half_s & aluoutM[0]) | (is_word_s & (aluoutM[1:0] != 2'b00));
    assign adelM        = active_s & misaligned_s & ~wr_s;
    assign adesM        = active_s & misaligned_s & wr_s;
    assign badvaddrM    = (adelM | adesM) ? aluoutM : 32'h0000_0000;
`else
    assign misaligned_s = 1'b0;
    assign adelM        = 1'b0;
    assign adesM        = 1'b0;
    assign badvaddrM    = 32'h0000_0000;
`endif

    // Byte-lane enables and lane-replicated store data for the current M op.
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = writedataM;
        case (lsopM)
            3'b011, 3'b100: begin
                be_s    = 4'b0001 << aluoutM[1:0];
                wdata_s = writedataM;
            end
            3'b111: begin
                be_s    = 4'b0001 << aluoutM[1:0];
                wdata_s = {4{writedataM[7:0]}};
            end
            3'b001, 3'b010: begin
                be_s    = aluoutM[1] ? 4'b1100 : 4'b0011;
                wdata_s = writedataM;
            end
            3'b110: begin
                be_s    = aluoutM[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{writedataM[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = writedataM;
            end
        endcase
    end

    // Transaction FSM; bus outputs and load result are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_addr  <= 32'h0000_0000;
            data_be    <= 4'b0000;
            data_wdata <= 32'h0000_0000;
            readdataM  <= 32'h0000_0000;
            off_r      <= 2'b00;
            lsop_r     <= 3'b000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (issue_s) begin
                        state_r    <= WAIT;
                        data_req   <= 1'b1;
                        data_wr    <= wr_s;
                        data_addr  <= {aluoutM[31:2], 2'b00};
                        data_be    <= be_s;
                        data_wdata <= wdata_s;
                        off_r      <= aluoutM[1:0];
                        lsop_r     <= lsopM;
                    end
                end
                WAIT: begin
                    if (data_ack) begin
                        state_r  <= DONE;
                        data_req <= 1'b0;
                        if (!data_wr) begin
                            readdataM <= extract_load(lsop_r, off_r, data_rdata);
                        end
                    end
                end
                // memenM still belongs to the finished instruction here, so never re-issue.
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    data_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; drives and samples on the falling clock edge.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        memenM;
    logic [2:0]  lsopM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        flushM;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ack;
    logic [31:0] readdataM;
    logic        stallM;
    logic        adelM;
    logic        adesM;
    logic [31:0] badvaddrM;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int          obs_stall;
    int          obs_rise_cyc;
    bit          obs_timeout;
    bit          obs_stable;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    logic [31:0] obs_addr;
    logic        obs_wr;
    logic        obs_adel;
    logic        obs_done_req;
    logic        obs_done_stall;
    logic [31:0] obs_rd;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .memenM(memenM), .lsopM(lsopM), .aluoutM(aluoutM),
        .writedataM(writedataM), .flushM(flushM), .data_req(data_req), .data_wr(data_wr),
        .data_addr(data_addr), .data_be(data_be), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_ack(data_ack), .readdataM(readdataM),
        .stallM(stallM), .adelM(adelM), .adesM(adesM), .badvaddrM(badvaddrM)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drives one access with 'waits' ack-less WAIT cycles and records what was seen.
    task automatic run_access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int waits, input bit keep);
        int n;
        @(negedge clk);
        memenM = 1'b1; lsopM = op; aluoutM = addr; writedataM = wd; data_ack = 1'b0; flushM = 1'b0;
        #1;
        obs_stall = (stallM === 1'b1) ? 1 : 0;
        obs_adel = adelM;
        obs_timeout = 1'b0;
        obs_stable = 1'b1;
        n = 0;
        @(negedge clk);
        while (data_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (data_req !== 1'b1) begin
            obs_timeout = 1'b1;
            memenM = 1'b0;
            return;
        end
        obs_rise_cyc = cyc;
        obs_be = data_be; obs_wdata = data_wdata; obs_addr = data_addr; obs_wr = data_wr;
        for (int i = 0; i < waits; i++) begin
            obs_stall += (stallM === 1'b1) ? 1 : 0;
            @(negedge clk);
            if (data_req !== 1'b1 || data_be !== obs_be || data_wdata !== obs_wdata ||
                data_addr !== obs_addr || data_wr !== obs_wr)
                obs_stable = 1'b0;
        end
        obs_stall += (stallM === 1'b1) ? 1 : 0;
        data_ack = 1'b1; data_rdata = rd;
        @(negedge clk);
        data_ack = 1'b0;
        obs_done_req = data_req; obs_done_stall = stallM; obs_rd = readdataM;
        if (!keep) memenM = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; memenM = 1'b0; lsopM = 3'b000; aluoutM = 32'h0; writedataM = 32'h0;
        flushM = 1'b0; data_rdata = 32'h0; data_ack = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (data_req !== 1'b0 || stallM !== 1'b0 || readdataM !== 32'h0 || data_be !== 4'b0000 ||
            data_addr !== 32'h0 || data_wr !== 1'b0 || data_wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: req=%b stall=%b rd=%h be=%b got, all zero expected",
                     data_req, stallM, readdataM, data_be);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lw();
        run_access(3'b000, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        vectors++;
        if (obs_timeout || obs_stall != 2 || obs_rd !== 32'hDEAD_BEEF || obs_be !== 4'b1111 ||
            obs_addr !== 32'h0000_0100 || obs_wr !== 1'b0 || obs_done_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL lw: to=%0b stall=%0d rd=%h be=%b addr=%h wr=%b, expected stall=2 rd=deadbeef be=1111 addr=100 wr=0",
                     obs_timeout, obs_stall, obs_rd, obs_be, obs_addr, obs_wr);
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  ops [4]  = '{3'b011, 3'b100, 3'b001, 3'b010};
        logic [31:0] adrs [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
        logic [31:0] rds [4]  = '{32'h8011_2233, 32'h8011_2233, 32'h8011_2233, 32'h8011_8233};
        logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011, 32'h0000_8233};
        logic [3:0]  bes [4]  = '{4'b1000, 4'b1000, 4'b1100, 4'b0011};
        for (int i = 0; i < 4; i++) begin
            run_access(ops[i], adrs[i], 32'h0, rds[i], 0, 1'b0);
            vectors++;
            if (obs_timeout || obs_rd !== exps[i] || obs_be !== bes[i] || obs_stall != 2) begin
                miscompares++;
                $display("FAIL load_ext[%0d]: rd=%h be=%b stall=%0d, expected rd=%h be=%b stall=2",
                         i, obs_rd, obs_be, obs_stall, exps[i], bes[i]);
            end
        end
    endtask

    task automatic test_stores();
        run_access(3'b110, 32'h0000_0202, 32'h0000_ABCD, 32'h5555_5555, 3, 1'b0);
        vectors++;
        if (obs_timeout || obs_be !== 4'b1100 || obs_wdata !== 32'hABCD_ABCD || obs_wr !== 1'b1 ||
            obs_addr !== 32'h0000_0200 || !obs_stable || obs_stall != 5 || obs_rd !== 32'h0000_8233) begin
            miscompares++;
            $display("FAIL sh: be=%b wd=%h wr=%b addr=%h stable=%0b stall=%0d rd=%h, expected 1100 abcdabcd 1 200 1 5 00008233",
                     obs_be, obs_wdata, obs_wr, obs_addr, obs_stable, obs_stall, obs_rd);
        end
        run_access(3'b111, 32'h0000_0301, 32'h1234_5678, 32'h0, 0, 1'b0);
        vectors++;
        if (obs_timeout || obs_be !== 4'b0010 || obs_wdata !== 32'h7878_7878 || obs_wr !== 1'b1 ||
            obs_rd !== 32'h0000_8233) begin
            miscompares++;
            $display("FAIL sb: be=%b wd=%h wr=%b rd=%h, expected 0010 78787878 1 00008233",
                     obs_be, obs_wdata, obs_wr, obs_rd);
        end
        run_access(3'b101, 32'h0000_0304, 32'hA5A5_0F0F, 32'h0, 1, 1'b0);
        vectors++;
        if (obs_timeout || obs_be !== 4'b1111 || obs_wdata !== 32'hA5A5_0F0F || obs_wr !== 1'b1 ||
            obs_stall != 3) begin
            miscompares++;
            $display("FAIL sw: be=%b wd=%h wr=%b stall=%0d, expected 1111 a5a50f0f 1 3",
                     obs_be, obs_wdata, obs_wr, obs_stall);
        end
    endtask

    task automatic test_non_mem();
        @(negedge clk);
        memenM = 1'b0; lsopM = 3'b000; aluoutM = 32'h0000_0101;
        repeat (2) @(negedge clk);
        vectors++;
        if (stallM !== 1'b0 || data_req !== 1'b0 || adelM !== 1'b0) begin
            miscompares++;
            $display("FAIL non_mem: stall=%b req=%b adel=%b, expected 0 0 0", stallM, data_req, adelM);
        end
    endtask

    task automatic test_back_to_back();
        int r1;
        run_access(3'b000, 32'h0000_0400, 32'h0, 32'h1111_1111, 0, 1'b1);
        r1 = obs_rise_cyc;
        vectors++;
        if (obs_timeout || obs_done_req !== 1'b0 || obs_done_stall !== 1'b0 || obs_rd !== 32'h1111_1111) begin
            miscompares++;
            $display("FAIL b2b_first: req_in_done=%b stall_in_done=%b rd=%h, expected 0 0 11111111",
                     obs_done_req, obs_done_stall, obs_rd);
        end
        run_access(3'b000, 32'h0000_0404, 32'h0, 32'h2222_2222, 0, 1'b0);
        vectors++;
        if (obs_timeout || (obs_rise_cyc - r1) != 3 || obs_rd !== 32'h2222_2222 || obs_addr !== 32'h0000_0404) begin
            miscompares++;
            $display("FAIL b2b_spacing: gap=%0d rd=%h addr=%h, expected gap=3 rd=22222222 addr=404",
                     obs_rise_cyc - r1, obs_rd, obs_addr);
        end
    endtask

    task automatic test_misalign();
`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        memenM = 1'b1; lsopM = 3'b000; aluoutM = 32'h0000_0101; flushM = 1'b0;
        #1;
        vectors++;
        if (adelM !== 1'b1 || adesM !== 1'b0 || badvaddrM !== 32'h0000_0101 || stallM !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_lw: adel=%b ades=%b bad=%h stall=%b, expected 1 0 101 0",
                     adelM, adesM, badvaddrM, stallM);
        end
        lsopM = 3'b110; aluoutM = 32'h0000_0203;
        #1;
        vectors++;
        if (adesM !== 1'b1 || adelM !== 1'b0 || badvaddrM !== 32'h0000_0203 || stallM !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_sh: ades=%b adel=%b bad=%h stall=%b, expected 1 0 203 0",
                     adesM, adelM, badvaddrM, stallM);
        end
        @(negedge clk);
        vectors++;
        if (data_req !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_noreq: req=%b, expected 0", data_req);
        end
        memenM = 1'b0;
`else
        run_access(3'b000, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
        vectors++;
        if (obs_timeout || obs_addr !== 32'h0000_0100 || obs_be !== 4'b1111 ||
            obs_rd !== 32'hCAFE_F00D || obs_adel !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_lw: to=%0b addr=%h be=%b rd=%h adel=%b, expected 0 100 1111 cafef00d 0",
                     obs_timeout, obs_addr, obs_be, obs_rd, obs_adel);
        end
`endif
    endtask

    task automatic test_flush();
        @(negedge clk);
        memenM = 1'b1; lsopM = 3'b000; aluoutM = 32'h0000_0500; flushM = 1'b1;
        #1;
        vectors++;
        if (stallM !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle_stall: stall=%b, expected 0", stallM);
        end
        @(negedge clk);
        vectors++;
        if (data_req !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle_req: req=%b, expected 0", data_req);
        end
        flushM = 1'b0;
        @(negedge clk);
        flushM = 1'b1;
        #1;
        vectors++;
        if (data_req !== 1'b1 || stallM !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_wait: req=%b stall=%b, expected 1 1", data_req, stallM);
        end
        data_ack = 1'b1; data_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        data_ack = 1'b0; memenM = 1'b0; flushM = 1'b0;
        vectors++;
        if (readdataM !== 32'h0BAD_F00D || data_req !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_complete: rd=%h req=%b, expected 0badf00d 0", readdataM, data_req);
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        memenM = 1'b1; lsopM = 3'b000; aluoutM = 32'h0000_0600;
        @(negedge clk);
        rst = 1'b1; memenM = 1'b0;
        #1;
        vectors++;
        if (data_req !== 1'b0 || stallM !== 1'b0 || readdataM !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_wait: req=%b stall=%b rd=%h, expected 0 0 00000000", data_req, stallM, readdataM);
        end
        @(negedge clk);
        rst = 1'b0;
        run_access(3'b000, 32'h0000_0700, 32'h0, 32'h1122_3344, 0, 1'b0);
        vectors++;
        if (obs_timeout || obs_stall != 2 || obs_rd !== 32'h1122_3344) begin
            miscompares++;
            $display("FAIL reset_recover: to=%0b stall=%0d rd=%h, expected 0 2 11223344",
                     obs_timeout, obs_stall, obs_rd);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_extend();
        test_stores();
        test_non_mem();
        test_back_to_back();
        test_misalign();
        test_flush();
        test_reset_mid_wait();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data-access controller that sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns a load/store in M into a single request/acknowledge transaction on the data-SRAM port. It aligns store data and byte enables, and sign- or zero-extends load data into `readdataM`. While the transaction is outstanding it stalls the pipeline through `stallM`.

## Interface
Parameters: none.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- memenM  in  1  M-stage instruction is a load/store
- lsopM  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
- aluoutM  in  32  effective byte address
- writedataM  in  32  store source register value
- flushM  in  1  kill the M-stage instruction (sampled in IDLE only)
- data_req  out  1  request valid, held until ack
- data_wr  out  1  1 = store, 0 = load
- data_addr  out  32  word address {addr[31:2],2'b00}
- data_be  out  4  byte enables, little-endian lanes
- data_wdata  out  32  lane-replicated store data
- data_rdata  in  32  read word, valid with ack
- data_ack  in  1  transaction complete
- readdataM  out  32  extended load result, registered
- stallM  out  1  freeze IF..M and hold MEM/WB input
- adelM  out  1  load address error
- adesM  out  1  store address error
- badvaddrM  out  32  faulting address

## Operation
- FSM states: IDLE, WAIT, DONE.
- Issue condition in IDLE: memenM & ~flushM & ~misaligned.
  - On issue, go to WAIT.
  - Register data_req=1, data_wr=lsopM[2]&(lsopM!=100), data_addr, data_be, data_wdata and the 2-bit offset/lsop for extraction.
- WAIT:
  - data_req stays high; addr/be/wdata/wr are held constant.
  - On data_ack: data_req←0, go to DONE.
  - On a load ack, readdataM←extracted data_rdata.
  - On a store ack, readdataM is unchanged.
- DONE: unconditionally go to IDLE. No new issue is allowed in DONE, because memenM still belongs to the completed instruction.
- stallM = (IDLE & issue condition) | WAIT. stallM is combinational and is 0 in DONE.
- data_be values:
  - byte ops (LB/LBU/SB): 1<<addr[1:0]
  - halfword ops (LH/LHU/SH): addr[1] ? 1100 : 0011
  - word ops: 1111
- data_wdata values: SB {4{wd[7:0]}}, SH {2{wd[15:0]}}, SW wd.
- Load extraction: select the byte or halfword using the registered offset. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- misaligned: halfword op with addr[0]=1, or word op with addr[1:0]≠00. It is evaluated only under the macro (see Configuration).
- adelM/adesM/badvaddrM are combinational from M inputs, and are asserted only in IDLE with memenM & ~flushM.
- flushM in WAIT/DONE is ignored: a bus transaction is never aborted.
- Reset values (async): state IDLE, data_req 0, data_wr 0, data_addr 0, data_be 0, data_wdata 0, readdataM 0. Derived outputs follow: stallM 0, adelM/adesM 0, badvaddrM 0. Reset mid-WAIT drops the request immediately; the SRAM side must tolerate the abandoned request.

## Timing
- Minimum residency in M is 3 cycles: issue (IDLE), WAIT with same-cycle ack, DONE.
- Each extra ack-wait cycle adds one cycle.
- data_req rises on the clock edge after issue; ack is sampled at clock edges while in WAIT.
- readdataM is valid during DONE. MEM/WB captures it at the edge that ends DONE.
- Back-to-back memory instructions: the next one enters M at the end of DONE, and its issue cycle is the following IDLE. Sustained throughput is 1 access per 3 cycles at zero wait.
- Non-memory instructions pass with no stall.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A misaligned access suppresses issue; stallM stays 0.
  - adelM (loads) or adesM (stores) is asserted for that cycle, with badvaddrM=aluoutM.
- MEM_ALIGN_CHECK_EN undefined:
  - The misaligned term is constant 0, and adelM/adesM/badvaddrM are tied 0.
  - The access is issued with addr[1:0] ignored for word ops and addr[0] ignored for halfword ops.

## Test plan
- LW at 0x100, rdata 0xDEADBEEF, ack one cycle after req → stallM high for 2 cycles, readdataM=0xDEADBEEF in DONE, data_be=1111.
- LB at 0x103, rdata 0x80112233, zero wait → readdataM=0xFFFFFF80; LBU at the same address → 0x00000080.
- SH at 0x202, wd 0x0000ABCD, 3 wait cycles → data_be=1100, data_wdata=0xABCDABCD, data_wr=1, signals stable through all WAIT cycles, readdataM unchanged.
- Two consecutive LWs, zero wait → second data_req rises exactly 3 cycles after the first; no duplicate request in DONE.
- With MEM_ALIGN_CHECK_EN: LW at 0x101 → no data_req, adelM=1, badvaddrM=0x101, stallM=0. Without the macro: data_req issued, data_addr=0x100.
- rst pulsed while in WAIT → data_req=0 and stallM=0 immediately, FSM in IDLE; flushM during WAIT → transaction still completes.
